alarm_controller: RTL and testbench

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_controller.sv | 80 ++++++++
 tb/tb_alarm_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// alarm_controller: daily alarm FSM with ring timeout, snooze retarget and validated alarm loading
module alarm_controller #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       alarm_en,
  input  logic       alarm_set,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       snooze,
  input  logic       stop,
  output logic       alarm_on,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic [1:0] state,
  output logic       set_err
);
  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZED} state_t;
  state_t cur, nxt;
  logic [7:0] ring_cnt, ring_nxt;
  logic [4:0] snz_h, snz_h_nxt;
  logic [5:0] snz_m, snz_m_nxt;
  logic [6:0] m_sum;
  logic at_alarm, at_snz, set_ok, ring_done;
  assign state     = cur;
  assign at_alarm  = seconds == 6'd0 && hours == alarm_hours && minutes == alarm_minutes;
  assign at_snz    = seconds == 6'd0 && hours == snz_h && minutes == snz_m;
  assign set_ok    = set_hours <= 5'd23 && set_minutes <= 6'd59;
  assign ring_done = ring_cnt == 8'(RING_SECS - 1);
  assign m_sum     = {1'b0, minutes} + 7'(SNOOZE_MINS);
  always_comb begin
    nxt       = cur;
    ring_nxt  = ring_cnt;
    snz_h_nxt = snz_h;
    snz_m_nxt = snz_m;
    if (!alarm_en) nxt = IDLE;
    else case (cur)
      IDLE:    nxt = ARMED;
      ARMED:   if (at_alarm) begin nxt = RINGING; ring_nxt = 8'd0; end
      RINGING: if (stop) nxt = ARMED;
        else if (snooze) begin
          nxt       = SNOOZED;
          snz_m_nxt = m_sum >= 7'd60 ? 6'(m_sum - 7'd60) : m_sum[5:0];
          snz_h_nxt = m_sum < 7'd60 ? hours : hours == 5'd23 ? 5'd0 : hours + 5'd1;
        end
        else if (ring_done) nxt = ARMED;
        else ring_nxt = ring_cnt + 8'd1;
      SNOOZED: if (stop) nxt = ARMED;
        else if (at_snz) begin nxt = RINGING; ring_nxt = 8'd0; end
    endcase
  end
  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      cur           <= IDLE;
      alarm_on      <= 1'b0;
      ring_cnt      <= 8'd0;
      snz_h         <= 5'd0;
      snz_m         <= 6'd0;
      alarm_hours   <= 5'd0;
      alarm_minutes <= 6'd0;
      set_err       <= 1'b0;
    end else begin
      cur      <= nxt;
      alarm_on <= nxt == RINGING;
      ring_cnt <= ring_nxt;
      snz_h    <= snz_h_nxt;
      snz_m    <= snz_m_nxt;
      set_err  <= alarm_set && !set_ok;
      if (alarm_set && set_ok) begin
        alarm_hours   <= set_hours;
        alarm_minutes <= set_minutes;
      end
    end
  end
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: randomized + directed checks against a time-of-day reference model
module tb_alarm_controller;
  localparam int RS = 60, SZ = 5;
  logic clk_1Hz = 0, rst = 1;
  logic [5:0] seconds, minutes, set_minutes;
  logic [4:0] hours, set_hours;
  logic alarm_en = 0, alarm_set = 0, snooze = 0, stop = 0;
  logic alarm_on, set_err;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic [1:0] state;
  int checks = 0, errs = 0, tod = 0, n;
  bit go = 0;
  int m_state = 0, m_ah = 0, m_am = 0, m_err = 0, m_ring = 0, m_snz = 0;

  alarm_controller #(.RING_SECS(RS), .SNOOZE_MINS(SZ)) dut (
    .clk_1Hz(clk_1Hz), .rst(rst), .seconds(seconds), .minutes(minutes), .hours(hours),
    .alarm_en(alarm_en), .alarm_set(alarm_set), .set_hours(set_hours), .set_minutes(set_minutes),
    .snooze(snooze), .stop(stop), .alarm_on(alarm_on), .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes), .state(state), .set_err(set_err));

  always #5 clk_1Hz = ~clk_1Hz;
  assign hours   = 5'(tod / 3600);
  assign minutes = 6'((tod / 60) % 60);
  assign seconds = 6'(tod % 60);

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ah = 0; m_am = 0; m_err = 0; m_ring = 0; m_snz = 0;
  endtask

  // Reference: times as minute-of-day, snooze target via modulo-1440 arithmetic
  task automatic model_step();
    int now_min, ns;
    now_min = tod / 60;
    if (rst) begin model_reset(); return; end
    ns = m_state;
    if (!alarm_en) ns = 0;
    else if (m_state == 0) ns = 1;
    else if (m_state == 1) begin
      if (tod % 60 == 0 && now_min == m_ah * 60 + m_am) begin ns = 2; m_ring = 0; end
    end else if (m_state == 2) begin
      if (stop) ns = 1;
      else if (snooze) begin ns = 3; m_snz = (now_min + SZ) % 1440; end
      else if (m_ring + 1 >= RS) ns = 1;
      else m_ring++;
    end else begin
      if (stop) ns = 1;
      else if (tod % 60 == 0 && now_min == m_snz) begin ns = 2; m_ring = 0; end
    end
    m_state = ns;
    m_err = (alarm_set && (set_hours > 23 || set_minutes > 59)) ? 1 : 0;
    if (alarm_set && set_hours <= 23 && set_minutes <= 59) begin m_ah = set_hours; m_am = set_minutes; end
  endtask

  task automatic cycle();
    @(posedge clk_1Hz);
    model_step();
    #1;
  endtask

  task automatic set_time(int h, int m, int s);
    tod = h * 3600 + m * 60 + s;
  endtask

  always @(negedge clk_1Hz) if (go) begin
    checks++;
    if (state != 2'(m_state) || alarm_on != (m_state == 2) || alarm_hours != 5'(m_ah) ||
        alarm_minutes != 6'(m_am) || set_err != 1'(m_err)) begin
      errs++;
      $display("FAIL model t=%0t: got st=%0d on=%0d ah=%0d am=%0d err=%0d expected st=%0d on=%0d ah=%0d am=%0d err=%0d",
               $time, state, alarm_on, alarm_hours, alarm_minutes, set_err,
               m_state, m_state == 2, m_ah, m_am, m_err);
    end
  end

  initial begin
    set_hours = 0; set_minutes = 0;
    cycle(); cycle();
    go = 1;
    chk("reset_state", state, 0); chk("reset_on", alarm_on, 0);
    chk("reset_ah", alarm_hours, 0); chk("reset_err", set_err, 0);
    rst = 0;
    // alarm 06:30 triggers at 06:30:00
    alarm_set = 1; set_hours = 6; set_minutes = 30; alarm_en = 1; set_time(6, 29, 50);
    cycle();
    alarm_set = 0;
    chk("load_h", alarm_hours, 6); chk("load_m", alarm_minutes, 30); chk("armed", state, 1);
    for (int i = 0; i < 9; i++) begin tod++; cycle(); end
    chk("no_early", state, 1);
    tod++; cycle();
    chk("ring_state", state, 2); chk("ring_on", alarm_on, 1);
    n = 1;
    for (int i = 0; i < 200 && alarm_on; i++) begin tod++; cycle(); if (alarm_on) n++; end
    chk("ring_len", n, 60); chk("timeout_armed", state, 1);
    set_time(6, 30, 30);
    for (int i = 0; i < 29; i++) begin cycle(); tod++; end
    chk("no_retrigger", state, 1);
    // invalid set
    alarm_set = 1; set_hours = 24; set_minutes = 10; cycle(); alarm_set = 0;
    chk("err_pulse", set_err, 1); chk("err_keep_h", alarm_hours, 6); chk("err_keep_m", alarm_minutes, 30);
    cycle();
    chk("err_clear", set_err, 0);
    // snooze across midnight
    alarm_set = 1; set_hours = 23; set_minutes = 58; set_time(23, 57, 59); cycle(); alarm_set = 0;
    set_time(23, 58, 0); cycle();
    chk("ring2", state, 2);
    for (int i = 0; i < 9; i++) begin tod++; cycle(); end
    tod++; snooze = 1; cycle(); snooze = 0;
    chk("snoozed", state, 3);
    set_time(0, 2, 58); cycle(); chk("snz_wait1", state, 3);
    tod++; cycle(); chk("snz_wait2", state, 3);
    tod++; cycle(); chk("snz_ring", state, 2); chk("snz_on", alarm_on, 1);
    // stop beats snooze; alarm_en low beats stop
    stop = 1; snooze = 1; cycle(); stop = 0; snooze = 0;
    chk("stop_wins", state, 1);
    set_time(23, 58, 0); cycle(); chk("ring3", state, 2);
    stop = 1; alarm_en = 0; cycle(); stop = 0; alarm_en = 1;
    chk("en_wins", state, 0);
    cycle(); set_time(23, 58, 0); cycle(); chk("ring4", state, 2);
    // asynchronous reset mid-ring
    #2 rst = 1; model_reset(); #1;
    chk("async_on", alarm_on, 0); chk("async_state", state, 0); chk("async_ah", alarm_hours, 0);
    chk("async_am", alarm_minutes, 0); chk("async_err", set_err, 0);
    cycle(); rst = 0; #1;
    chk("post_rst_idle", state, 0);
    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      alarm_en = $urandom_range(0, 99) < 96;
      alarm_set = $urandom_range(0, 99) < 4;
      set_hours = 5'($urandom_range(0, 25)); set_minutes = 6'($urandom_range(0, 62));
      snooze = $urandom_range(0, 99) < 4;
      stop = $urandom_range(0, 99) < 2;
      n = $urandom_range(0, 99);
      if (n < 4) tod = (m_ah * 3600 + m_am * 60 - 2 + 86400) % 86400;
      else if (n < 9 && m_state == 3) tod = (m_snz * 60 - 2 + 86400) % 86400;
      else tod = (tod + 1) % 86400;
      if ($urandom_range(0, 999) < 3) begin
        rst = 1; model_reset(); #1;
        chk("rnd_async_on", alarm_on, 0);
        cycle(); rst = 0;
      end else cycle();
    end
    go = 0;
    $display("%0d/%0d checks passed", checks - errs, checks);
    $finish;
  end
endmodule
